// File: rtl/clk_div_pkg.sv
// Shared types and constants for the divided-clock checker.
package clk_div_pkg;

  // Measurement FSM: SEEK waits for a first rise, HIGH/LOW time the two phases.
  typedef enum logic [1:0] {
    SEEK = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  // Default duration-counter width and its saturation value.
  localparam int              CW_DEF  = 8;
  localparam logic [CW_DEF-1:0] CNT_MAX = '1;

endpackage

// File: rtl/clk_edge_sync.sv
// Brings clk_div into the clk_in domain and produces one-cycle rise/fall strobes.
module clk_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic clk_div,
  output logic rise,
  output logic fall
);

  logic s;
  logic s_d_q;

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign s = clk_div;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      // Synchronizer chain: stage 0 samples the asynchronous divided clock.
      always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= clk_div;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end

      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Delayed copy of the synchronized level for edge detection.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      s_d_q <= 1'b0;
    end else begin
      s_d_q <= s;
    end
  end

  assign rise = s & ~s_d_q;
  assign fall = ~s & s_d_q;

endmodule

// File: rtl/clk_div_checker.sv
// Measures high/low/period of a divided clock in clk_in cycles, checks it
// against the expected ratio, tracks lock and flags a stopped divided clock.
module clk_div_checker
  import clk_div_pkg::*;
#(
  parameter int EXP_N       = 5,
  parameter int CW          = CW_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CNT    = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          clk_div,
  output logic [CW-1:0] hi_len,
  output logic [CW-1:0] lo_len,
  output logic [CW-1:0] period,
  output logic          meas_vld,
  output logic          err,
  output logic          locked,
  output logic          stuck
);

  localparam int            LW      = $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0] CNT_SAT = '1;
  localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT);
  localparam logic [CW-1:0] EXP_VAL = CW'(EXP_N);
  localparam logic [CW-1:0] HALF_LO = CW'(EXP_N / 2);
  localparam logic [CW-1:0] HALF_HI = CW'(EXP_N - EXP_N / 2);
  localparam logic [LW-1:0] LOCK_VAL = LW'(LOCK_CNT);

  logic rise, fall, any_edge;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] hi_q, hi_d;
  logic [CW-1:0] hi_len_q, hi_len_d;
  logic [CW-1:0] lo_len_q, lo_len_d;
  logic [CW-1:0] period_q, period_d;
  logic          meas_vld_q, meas_vld_d;
  logic          err_q, err_d;
  logic          locked_q, locked_d;
  logic          stuck_q, stuck_d;
  logic [LW-1:0] lock_q, lock_d;

  logic [CW:0]   sum_w;
  logic [CW-1:0] per_sat;
  logic          good;

  clk_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .clk_div(clk_div),
    .rise   (rise),
    .fall   (fall)
  );

  assign any_edge = rise | fall;

  // Phase duration counter: restarts at 1 on every edge, saturates otherwise.
  always_comb begin
    if (any_edge) begin
      cnt_d = CW'(1);
    end else if (cnt_q == CNT_SAT) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Candidate period from the stored high time and the current low count.
  always_comb begin
    sum_w   = {1'b0, hi_q} + {1'b0, cnt_q};
    per_sat = sum_w[CW] ? CNT_SAT : sum_w[CW-1:0];
    good    = (per_sat == EXP_VAL)
           && ((hi_q  == HALF_LO) || (hi_q  == HALF_HI))
           && ((cnt_q == HALF_LO) || (cnt_q == HALF_HI));
  end

  // FSM next state, publish values, lock tracking and timeout.
  // NOTE: every signal gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    hi_len_d   = hi_len_q;
    lo_len_d   = lo_len_q;
    period_d   = period_q;
    meas_vld_d = 1'b0;
    err_d      = 1'b0;
    stuck_d    = 1'b0;
    lock_d     = lock_q;
    locked_d   = locked_q;

    unique case (state_q)
      SEEK: begin
        if (rise) state_d = HIGH;
      end
      HIGH: begin
        if (fall) begin
          hi_d    = cnt_q;
          state_d = LOW;
        end else if (cnt_q == TO_VAL) begin
          stuck_d  = 1'b1;
          locked_d = 1'b0;
          lock_d   = '0;
          state_d  = SEEK;
        end
      end
      LOW: begin
        if (rise) begin
          hi_len_d   = hi_q;
          lo_len_d   = cnt_q;
          period_d   = per_sat;
          meas_vld_d = 1'b1;
          state_d    = HIGH;
          if (good) begin
            lock_d   = (lock_q == LOCK_VAL) ? lock_q : lock_q + LW'(1);
            locked_d = (lock_d == LOCK_VAL);
          end else begin
            err_d    = 1'b1;
            lock_d   = '0;
            locked_d = 1'b0;
          end
        end else if (cnt_q == TO_VAL) begin
          stuck_d  = 1'b1;
          locked_d = 1'b0;
          lock_d   = '0;
          state_d  = SEEK;
        end
      end
      default: state_d = SEEK;
    endcase
  end

  // State, counter and published registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q    <= SEEK;
      cnt_q      <= '0;
      hi_q       <= '0;
      hi_len_q   <= '0;
      lo_len_q   <= '0;
      period_q   <= '0;
      meas_vld_q <= 1'b0;
      err_q      <= 1'b0;
      locked_q   <= 1'b0;
      stuck_q    <= 1'b0;
      lock_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      hi_len_q   <= hi_len_d;
      lo_len_q   <= lo_len_d;
      period_q   <= period_d;
      meas_vld_q <= meas_vld_d;
      err_q      <= err_d;
      locked_q   <= locked_d;
      stuck_q    <= stuck_d;
      lock_q     <= lock_d;
    end
  end

  assign hi_len   = hi_len_q;
  assign lo_len   = lo_len_q;
  assign period   = period_q;
  assign meas_vld = meas_vld_q;
  assign err      = err_q;
  assign locked   = locked_q;
  assign stuck    = stuck_q;

endmodule

// File: tb/tb_clk_div_checker.sv
// Directed bench for clk_div_checker: an N=5 / 2-stage-sync instance (dut0)
// and an N=4 / unsynchronized instance (dut1) sharing clock and reset.
module tb_clk_div_checker;

  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_div0 = 1'b0;
  logic clk_div1 = 1'b0;

  logic [CW-1:0] hi_len0, lo_len0, period0, hi_len1, lo_len1, period1;
  logic meas_vld0, err0, locked0, stuck0;
  logic meas_vld1, err1, locked1, stuck1;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int step_no   = 0;

  // Captured view of the most recent publish on each instance.
  int vld0_cnt = 0, err0_cnt = 0, stuck0_cnt = 0, vld0_step = 0;
  int vld1_cnt = 0, err1_cnt = 0;
  logic [CW-1:0] c0_hi, c0_lo, c0_per, c1_hi, c1_lo, c1_per;
  logic c0_err, c0_locked, c1_err;

  clk_div_checker #(
    .EXP_N(5), .CW(CW), .SYNC_STAGES(2), .LOCK_CNT(4), .TIMEOUT(64)
  ) dut0 (
    .clk_in(clk), .rst(rst), .clk_div(clk_div0),
    .hi_len(hi_len0), .lo_len(lo_len0), .period(period0),
    .meas_vld(meas_vld0), .err(err0), .locked(locked0), .stuck(stuck0)
  );

  clk_div_checker #(
    .EXP_N(4), .CW(CW), .SYNC_STAGES(0), .LOCK_CNT(4), .TIMEOUT(64)
  ) dut1 (
    .clk_in(clk), .rst(rst), .clk_div(clk_div1),
    .hi_len(hi_len1), .lo_len(lo_len1), .period(period1),
    .meas_vld(meas_vld1), .err(err1), .locked(locked1), .stuck(stuck1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Advance one clk_in cycle and sample outputs 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    step_no++;
    if (meas_vld0) begin
      vld0_cnt++;
      vld0_step = step_no;
      c0_hi = hi_len0; c0_lo = lo_len0; c0_per = period0;
      c0_err = err0; c0_locked = locked0;
    end
    if (err0)   err0_cnt++;
    if (stuck0) stuck0_cnt++;
    if (meas_vld1) begin
      vld1_cnt++;
      c1_hi = hi_len1; c1_lo = lo_len1; c1_per = period1; c1_err = err1;
    end
    if (err1) err1_cnt++;
  endtask

  task automatic drive0(input int h, input int l);
    clk_div0 = 1'b1;
    repeat (h) step();
    clk_div0 = 1'b0;
    repeat (l) step();
  endtask

  task automatic drive1(input int h, input int l);
    clk_div1 = 1'b1;
    repeat (h) step();
    clk_div1 = 1'b0;
    repeat (l) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    total_cnt++;
    if ({hi_len0, lo_len0, period0, meas_vld0, err0, locked0, stuck0} !== '0)
      $display("FAIL reset_dut0: got %h expected 0",
               {hi_len0, lo_len0, period0, meas_vld0, err0, locked0, stuck0});
    else pass_cnt++;
    total_cnt++;
    if ({hi_len1, lo_len1, period1, meas_vld1, err1, locked1, stuck1} !== '0)
      $display("FAIL reset_dut1: got %h expected 0",
               {hi_len1, lo_len1, period1, meas_vld1, err1, locked1, stuck1});
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_first_meas();
    int s0;
    drive0(2, 3);
    total_cnt++;
    if (vld0_cnt !== 0) $display("FAIL first_rise_silent: got %0d expected 0", vld0_cnt);
    else pass_cnt++;
    s0 = step_no;
    drive0(2, 3);
    total_cnt++;
    if (vld0_cnt !== 1) $display("FAIL first_vld_count: got %0d expected 1", vld0_cnt);
    else pass_cnt++;
    // Rise applied before edge 1, seen by the FSM after 3 edges with two sync stages.
    total_cnt++;
    if (vld0_step !== s0 + 3) $display("FAIL sync2_latency: got %0d expected %0d", vld0_step - s0, 3);
    else pass_cnt++;
    total_cnt++;
    if ({c0_hi, c0_lo, c0_per} !== {8'd2, 8'd3, 8'd5})
      $display("FAIL first_meas: got hi=%0d lo=%0d per=%0d expected hi=2 lo=3 per=5", c0_hi, c0_lo, c0_per);
    else pass_cnt++;
    total_cnt++;
    if (c0_err !== 1'b0) $display("FAIL first_meas_err: got %0b expected 0", c0_err);
    else pass_cnt++;
  endtask

  task automatic test_lock();
    drive0(2, 3);
    drive0(2, 3);
    total_cnt++;
    if (c0_locked !== 1'b0) $display("FAIL lock_third_vld: got %0b expected 0", c0_locked);
    else pass_cnt++;
    drive0(2, 3);
    total_cnt++;
    if (c0_locked !== 1'b1 || vld0_cnt !== 4)
      $display("FAIL lock_fourth_vld: got locked=%0b vld=%0d expected locked=1 vld=4", c0_locked, vld0_cnt);
    else pass_cnt++;
    drive0(2, 3);
    drive0(2, 3);
    total_cnt++;
    if (locked0 !== 1'b1 || err0_cnt !== 0)
      $display("FAIL lock_hold: got locked=%0b errs=%0d expected locked=1 errs=0", locked0, err0_cnt);
    else pass_cnt++;
  endtask

  task automatic test_bad_period();
    drive0(2, 4);
    drive0(2, 3);
    total_cnt++;
    if (c0_per !== 8'd6 || c0_lo !== 8'd4)
      $display("FAIL bad_period_value: got per=%0d lo=%0d expected per=6 lo=4", c0_per, c0_lo);
    else pass_cnt++;
    total_cnt++;
    if (c0_err !== 1'b1 || c0_locked !== 1'b0)
      $display("FAIL bad_period_flags: got err=%0b locked=%0b expected err=1 locked=0", c0_err, c0_locked);
    else pass_cnt++;
    total_cnt++;
    if (err0_cnt !== 1) $display("FAIL bad_period_err_pulses: got %0d expected 1", err0_cnt);
    else pass_cnt++;
    repeat (3) drive0(2, 3);
    total_cnt++;
    if (locked0 !== 1'b0) $display("FAIL relock_early: got %0b expected 0", locked0);
    else pass_cnt++;
    drive0(2, 3);
    total_cnt++;
    if (locked0 !== 1'b1) $display("FAIL relock: got %0b expected 1", locked0);
    else pass_cnt++;
  endtask

  task automatic test_stuck();
    int   first_k = 0;
    int   st0;
    logic lk66 = 1'b0;
    clk_div0 = 1'b1;
    repeat (2) step();
    clk_div0 = 1'b0;
    st0 = stuck0_cnt;
    // Fall is registered at edge 3; stuck is registered 64 edges later.
    for (int k = 1; k <= 72; k++) begin
      step();
      if (stuck0 && first_k == 0) first_k = k;
      if (k == 66) lk66 = locked0;
    end
    total_cnt++;
    if (first_k !== 67) $display("FAIL stuck_timing: got edge %0d expected 67", first_k);
    else pass_cnt++;
    total_cnt++;
    if (lk66 !== 1'b1) $display("FAIL locked_before_stuck: got %0b expected 1", lk66);
    else pass_cnt++;
    total_cnt++;
    if (locked0 !== 1'b0) $display("FAIL stuck_unlock: got %0b expected 0", locked0);
    else pass_cnt++;
    total_cnt++;
    if (stuck0_cnt - st0 !== 1) $display("FAIL stuck_single_pulse: got %0d expected 1", stuck0_cnt - st0);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_high();
    int v;
    v = vld0_cnt;
    drive0(2, 3);
    total_cnt++;
    if (vld0_cnt !== v) $display("FAIL seek_rise_silent: got %0d expected %0d", vld0_cnt, v);
    else pass_cnt++;
    drive0(2, 3);
    clk_div0 = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({hi_len0, lo_len0, period0, meas_vld0, err0, locked0, stuck0} !== '0)
      $display("FAIL async_reset_clear: got %h expected 0",
               {hi_len0, lo_len0, period0, meas_vld0, err0, locked0, stuck0});
    else pass_cnt++;
    step();
    rst = 1'b0;
    v = vld0_cnt;
    step();
    clk_div0 = 1'b0;
    repeat (3) step();
    total_cnt++;
    if (vld0_cnt !== v) $display("FAIL post_reset_rise_silent: got %0d expected %0d", vld0_cnt, v);
    else pass_cnt++;
    drive0(2, 3);
    drive0(2, 3);
    total_cnt++;
    if (vld0_cnt !== v + 2 || c0_hi !== 8'd2 || c0_lo !== 8'd3 || c0_err !== 1'b0)
      $display("FAIL post_reset_meas: got vld=%0d hi=%0d lo=%0d err=%0b expected vld=%0d hi=2 lo=3 err=0",
               vld0_cnt - v, c0_hi, c0_lo, c0_err, 2);
    else pass_cnt++;
  endtask

  task automatic test_even_sync0();
    drive1(2, 2);
    total_cnt++;
    if (vld1_cnt !== 0) $display("FAIL n4_first_rise_silent: got %0d expected 0", vld1_cnt);
    else pass_cnt++;
    clk_div1 = 1'b1;
    step();
    total_cnt++;
    if (meas_vld1 !== 1'b1) $display("FAIL n4_latency: got %0b expected 1", meas_vld1);
    else pass_cnt++;
    total_cnt++;
    if ({c1_hi, c1_lo, c1_per, c1_err} !== {8'd2, 8'd2, 8'd4, 1'b0})
      $display("FAIL n4_meas: got hi=%0d lo=%0d per=%0d err=%0b expected hi=2 lo=2 per=4 err=0",
               c1_hi, c1_lo, c1_per, c1_err);
    else pass_cnt++;
    step();
    clk_div1 = 1'b0;
    repeat (2) step();
    repeat (3) drive1(2, 2);
    total_cnt++;
    if (locked1 !== 1'b1 || err1_cnt !== 0)
      $display("FAIL n4_lock: got locked=%0b errs=%0d expected locked=1 errs=0", locked1, err1_cnt);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_first_meas();
    test_lock();
    test_bad_period();
    test_stuck();
    test_reset_mid_high();
    test_even_sync0();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
